spi_slave_if: RTL and testbench

- SPI slave front end sitting directly upstream of the single-port 256x8 RAM in the SPI project.
- Deserialises MOSI frames into 10-bit words `{cmd[1:0], payload[7:0]}` and hands each one to the RAM with a one-cycle `rx_valid` strobe.
- For read-data frames, it waits for the RAM's `tx_valid`/`tx_data` response and serialises the byte back out on MISO.
- Runs on the SPI clock as the single system clock.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_if.sv | 23 ++
 rtl/spi_tx_shifter.sv | 50 +++++
 rtl/spi_slave_if.sv | 115 +++++++++++
 tb/tb_spi_slave_if.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: frame geometry, FSM encoding
// and the command codes the RAM decodes from rx_data[9:8].
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int TX_W    = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

endpackage

// File: rtl/spi_if.sv
// Bundle of the SPI pins plus the RAM-side rx/tx word handshake.
interface spi_if #(
  parameter int FRAME_W = spi_pkg::FRAME_W,
  parameter int TX_W    = spi_pkg::TX_W
);
  logic               ss_n;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [TX_W-1:0]    tx_data;
  logic               tx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_shifter.sv
// Parallel-load MSB-first serialiser for the MISO path; dout is the live MSB and
// falls back to 0 once the last bit has been presented for one cycle.
module spi_tx_shifter #(
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            shift_en,
  input  logic            clear,
  input  logic [TX_W-1:0] din,
  output logic            dout,
  output logic            done
);
  localparam int              CNT_W = $clog2(TX_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TX_W - 1);

  logic [TX_W-1:0]  data_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (clear) begin
      data_reg <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (load) begin
      data_reg <= din;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg && shift_en) begin
      if (cnt_reg == LAST) begin
        data_reg <= '0;
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        data_reg <= {data_reg[TX_W-2:0], 1'b0};
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

  assign dout = data_reg[TX_W-1];
  assign done = busy_reg && shift_en && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises {cmd, payload} frames for the RAM and, on
// read-data frames, serialises the RAM's response byte back out on MISO.
module spi_slave_if import spi_pkg::*; #(
  parameter int FRAME_W = spi_pkg::FRAME_W,
  parameter int TX_W    = spi_pkg::TX_W
) (
  input  logic clk,
  input  logic reset,
  spi_if.slave bus
);
  localparam logic [3:0] FRAME_CNT  = 4'(FRAME_W);
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_W - 1);

  state_t             state_reg, state_next;
  logic [3:0]         bit_cnt_reg, bit_cnt_next;
  logic [FRAME_W-1:0] shift_reg, shift_next;
  logic [FRAME_W-1:0] rx_data_reg, rx_data_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               rd_addr_done_reg, rd_addr_done_next;
  logic               tx_started_reg, tx_started_next;
  logic [FRAME_W-1:0] shift_in;
  logic               tx_load, tx_clear, tx_done, tx_dout;

  assign shift_in = {shift_reg[FRAME_W-2:0], bus.mosi};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_done_reg <= 1'b0;
      tx_started_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rd_addr_done_reg <= rd_addr_done_next;
      tx_started_reg   <= tx_started_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    bit_cnt_next      = bit_cnt_reg;
    shift_next        = shift_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rd_addr_done_next = rd_addr_done_reg;
    tx_started_next   = tx_started_reg;
    tx_load           = 1'b0;
    tx_clear          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!bus.ss_n) state_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (!bus.mosi)             state_next = WRITE;
        else if (!rd_addr_done_reg) state_next = READ_ADD;
        else                        state_next = READ_DATA;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (bit_cnt_reg < FRAME_CNT) begin
          shift_next   = shift_in;
          bit_cnt_next = bit_cnt_reg + 4'd1;
          if (bit_cnt_reg == FRAME_LAST) begin
            rx_data_next  = shift_in;
            rx_valid_next = 1'b1;
            if (state_reg == READ_ADD) rd_addr_done_next = 1'b1;
          end
        end else if (state_reg == READ_DATA && !tx_started_reg && bus.tx_valid) begin
          // Only the first response after the strobe is taken; later tx_valid is ignored.
          tx_load         = 1'b1;
          tx_started_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (tx_done) rd_addr_done_next = 1'b0;

    // Deselect overrides everything above, including a strobe on the 10th bit.
    if (bus.ss_n && state_reg != IDLE) begin
      state_next        = IDLE;
      bit_cnt_next      = '0;
      shift_next        = '0;
      rx_data_next      = rx_data_reg;
      rx_valid_next     = 1'b0;
      rd_addr_done_next = tx_started_reg ? 1'b0 : rd_addr_done_reg;
      tx_started_next   = 1'b0;
      tx_load           = 1'b0;
      tx_clear          = 1'b1;
    end
  end

  spi_tx_shifter #(.TX_W(TX_W)) u_tx (
    .clk      (clk),
    .reset    (reset),
    .load     (tx_load),
    .shift_en (state_reg == READ_DATA),
    .clear    (tx_clear),
    .din      (bus.tx_data),
    .dout     (tx_dout),
    .done     (tx_done)
  );

  assign bus.miso     = tx_dout;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_if.sv
// Frame-level stimulus for spi_slave_if with a queue-based scoreboard: the driver
// pushes per-edge expectations, a separate monitor pops and compares after each edge.
module tb_spi_slave_if;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_if bus ();

  spi_slave_if dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic rx_valid;
    logic miso;
  } exp_t;

  exp_t       cyc_q[$];
  logic [9:0] rx_q[$];
  int         checks   = 0;
  int         failures = 0;
  int         frame_no = 0;
  bit         model_rd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (frame %0d): got %0h, expected %0h", name, frame_no, act, exp);
    end
  endtask

  // Monitor: one expectation per driven edge, plus the rx word whenever rx_valid shows.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        exp_t x;
        x = cyc_q.pop_front();
        check("rx_valid", 32'(bus.rx_valid), 32'(x.rx_valid));
        check("miso", 32'(bus.miso), 32'(x.miso));
        if (bus.rx_valid === 1'b1) begin
          if (rx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected (frame %0d): got strobe with %0h, expected none", frame_no, bus.rx_data);
          end else begin
            check("rx_data", 32'(bus.rx_data), 32'(rx_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive(input logic ss, input logic m, input logic txv, input logic [7:0] txd,
                       input logic exp_rxv, input logic exp_miso);
    exp_t x;
    @(negedge clk);
    bus.ss_n     = ss;
    bus.mosi     = m;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    x.rx_valid   = exp_rxv;
    x.miso       = exp_miso;
    cyc_q.push_back(x);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_miso", 32'(bus.miso), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    bus.ss_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_rd_done = 1'b0;
  endtask

  // One ss_n-low period of L edges (E0..E(L-1)), then a deselect gap.
  // Read-data response arrives at edge k = 12 + d with byte tb.
  task automatic run_frame(input logic sel, input logic [9:0] word, input int L,
                           input int d, input logic [7:0] tb, input int reset_at);
    bit path_rd_data;
    bit full;
    int k;
    int gap;
    frame_no++;
    path_rd_data = sel && model_rd_done;
    full = (L >= 12);
    k = 12 + d;
    for (int e = 0; e < L; e++) begin
      logic       m, txv, expm;
      logic [7:0] txd;
      if (e == reset_at) begin
        reset_mid();
        return;
      end
      if (e == 1)                m = sel;
      else if (e >= 2 && e <= 11) m = word[11-e];
      else                        m = 1'($urandom);
      txv = 1'($urandom);
      txd = 8'($urandom);
      if (path_rd_data && e >= 12) begin
        if (e < k) txv = 1'b0;
        else if (e == k) begin
          txv = 1'b1;
          txd = tb;
        end
      end
      expm = 1'b0;
      if (path_rd_data && e >= k && e <= k + 7) expm = tb[7-(e-k)];
      if (e == 11) rx_q.push_back(word);
      drive(1'b0, m, txv, txd, (e == 11), expm);
    end
    if (full && sel) begin
      if (!model_rd_done)  model_rd_done = 1'b1;
      else if (k < L)      model_rd_done = 1'b0;
    end
    gap = 1 + int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++)
      drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    #1;
    check("reset_miso", 32'(bus.miso), 32'd0);
    check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_frame(1'b0, 10'h0A5, 14, 0, 8'h00, -1);   // write address
    run_frame(1'b0, 10'h13C, 13, 0, 8'h00, -1);   // write data
    run_frame(1'b1, 10'h2A5, 12, 0, 8'h00, -1);   // read address
    run_frame(1'b1, 10'h300, 24, 2, 8'hC3, -1);   // read data, full shift
    run_frame(1'b0, 10'h155, 8, 0, 8'h00, -1);    // abort after 6 data bits
    run_frame(1'b0, 10'h0FF, 12, 0, 8'h00, -1);
    run_frame(1'b1, 10'h1F0, 11, 0, 8'h00, -1);   // deselect on the 10th-bit edge
    run_frame(1'b1, 10'h2A5, 12, 0, 8'h00, -1);
    run_frame(1'b1, 10'h300, 40, 1, 8'h5A, 16);   // reset during MISO shift
    run_frame(1'b1, 10'h2A5, 12, 0, 8'h00, -1);   // must take the address path again
    run_frame(1'b1, 10'h3AA, 16, 0, 8'hFF, -1);   // abort mid-shift clears rd state
    run_frame(1'b1, 10'h2B4, 13, 0, 8'h00, -1);

    for (int i = 0; i < 40; i++) begin
      logic       sel;
      logic [9:0] word;
      logic [7:0] tb;
      int         L, d;
      sel  = 1'($urandom);
      word = 10'($urandom);
      tb   = 8'($urandom);
      d    = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) L = int'($urandom_range(1, 11));
      else                           L = 12 + int'($urandom_range(0, 24));
      run_frame(sel, word, L, d, tb, -1);
    end

    @(negedge clk);
    @(negedge clk);
    check("cycle_queue_drained", 32'(cyc_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
